// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multi-cycle RISC-V control sequencer:
//   - base opcode constants (instruction bits [6:0])
//   - sequencer state encoding (visible on the STATE port)
//   - PC-source and write-back-source select encodings
//   - instruction class enum produced by riscv_op_classify
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Base opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Sequencer states; the numeric values are exported on STATE
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // PC source select
    localparam logic [1:0] PCS_PC4     = 2'b00;
    localparam logic [1:0] PCS_PC_IMM  = 2'b01;
    localparam logic [1:0] PCS_RS1_IMM = 2'b10;

    // Register-file write-back source select
    localparam logic [1:0] DWS_ALU = 2'b00;
    localparam logic [1:0] DWS_MEM = 2'b01;
    localparam logic [1:0] DWS_PC4 = 2'b10;
    localparam logic [1:0] DWS_IMM = 2'b11;

    // Instruction classes that drive the sequencing decisions
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } insn_class_e;

endpackage

// File: rtl/riscv_op_classify.sv
// -----------------------------------------------------------------------------
// riscv_op_classify
// Purely combinational map from the 7-bit opcode to an instruction class.
// Ports:
//   op_code  in   7  opcode field of the instruction register
//   op_class out  3  instruction class (insn_class_e)
//   alu_imm  out  1  1 when the ALU class uses an immediate operand (OP-IMM)
// -----------------------------------------------------------------------------
import riscv_pkg::*;

module riscv_op_classify (
    input  logic [6:0]  op_code,
    output insn_class_e op_class,
    output logic        alu_imm
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        unique case (op_code)
            OPC_OP,
            OPC_OP_IMM: op_class = CLS_ALU;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_LUI:    op_class = CLS_LUI;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            default:    op_class = CLS_ILLEGAL;
        endcase
    end

    // R-type and I-type ALU ops share a class but differ in the B operand
    assign alu_imm = (op_code == OPC_OP_IMM);

endmodule

// File: rtl/riscv_mc_sequencer.sv
// -----------------------------------------------------------------------------
// riscv_mc_sequencer
// Multi-cycle control sequencer: steps each instruction through
// FETCH / DECODE / EXEC / MEM / WB, issues single-cycle PC, IR and register
// file write strobes, and handles ready-based memory handshakes. All datapath
// selects are decoded from the state register and the class latched in DECODE.
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous active-low reset
//   RUN        in   1      permits fetch of the next instruction
//   OP_CODE    in   7      opcode from IR (sampled in DECODE only)
//   FUNCT_3    in   3      funct3 from IR
//   BR_TAKEN   in   1      branch compare result (sampled in EXEC for branches)
//   IMEM_READY in   1      instruction memory data valid
//   DMEM_READY in   1      data memory access complete
//   IMEM_REQ   out  1      instruction fetch request
//   DMEM_REQ   out  1      data memory request
//   IRWE       out  1      IR load strobe
//   PCWE       out  1      PC load strobe
//   CRF        out  1      register-file write strobe
//   CDM        out  1      data memory write enable (qualifies DMEM_REQ)
//   PCS        out  2      PC source select
//   DWS        out  2      write-back source select
//   ALUS1      out  1      ALU A select (0 rs1, 1 PC)
//   ALUS2      out  1      ALU B select (0 rs2, 1 imm)
//   TRAP       out  1      sticky illegal-opcode flag
//   STATE      out  3      current state encoding
//   RETIRED    out  CNT_W  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
import riscv_pkg::*;

module riscv_mc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [6:0]       OP_CODE,
    input  logic [2:0]       FUNCT_3,
    input  logic             BR_TAKEN,
    input  logic             IMEM_READY,
    input  logic             DMEM_READY,
    output logic             IMEM_REQ,
    output logic             DMEM_REQ,
    output logic             IRWE,
    output logic             PCWE,
    output logic             CRF,
    output logic             CDM,
    output logic [1:0]       PCS,
    output logic [1:0]       DWS,
    output logic             ALUS1,
    output logic             ALUS2,
    output logic             TRAP,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] RETIRED
);

    state_e            state_q, state_d;
    insn_class_e       class_q, class_d;
    logic              alu_imm_q, alu_imm_d;
    logic              trap_q, trap_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              instr_end;

    insn_class_e       dec_class;
    logic              dec_alu_imm;

    // funct3 selects ALU operations in the control decoder; it has no
    // influence on the sequencing itself.
    logic              unused_funct3;
    assign unused_funct3 = ^FUNCT_3;

    riscv_op_classify u_classify (
        .op_code  (OP_CODE),
        .op_class (dec_class),
        .alu_imm  (dec_alu_imm)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_ALU;
            alu_imm_q <= 1'b0;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            alu_imm_q <= alu_imm_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        alu_imm_d = alu_imm_q;
        trap_d    = trap_q;
        retired_d = retired_q;
        instr_end = 1'b0;

        IMEM_REQ  = 1'b0;
        DMEM_REQ  = 1'b0;
        IRWE      = 1'b0;
        PCWE      = 1'b0;
        CRF       = 1'b0;
        CDM       = 1'b0;
        PCS       = PCS_PC4;
        DWS       = DWS_ALU;
        ALUS1     = 1'b0;
        ALUS2     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (RUN) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                IMEM_REQ = 1'b1;
                if (IMEM_READY) begin
                    IRWE    = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Latch the class so later states ignore the live opcode
                class_d   = dec_class;
                alu_imm_d = dec_alu_imm;
                unique case (dec_class)
                    CLS_LUI:     state_d = ST_WB;
                    CLS_ILLEGAL: begin
                        state_d = ST_HALT;
                        trap_d  = 1'b1;
                    end
                    default:     state_d = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                unique case (class_q)
                    CLS_ALU: begin
                        ALUS2   = alu_imm_q;
                        state_d = ST_WB;
                    end
                    CLS_LOAD,
                    CLS_STORE: begin
                        ALUS2   = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        PCWE      = 1'b1;
                        PCS       = BR_TAKEN ? PCS_PC_IMM : PCS_PC4;
                        instr_end = 1'b1;
                    end
                    CLS_JAL: begin
                        ALUS1   = 1'b1;
                        ALUS2   = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_JALR: begin
                        ALUS2   = 1'b1;
                        state_d = ST_WB;
                    end
                    default: state_d = ST_HALT;
                endcase
            end

            ST_MEM: begin
                DMEM_REQ = 1'b1;
                CDM      = (class_q == CLS_STORE);
                if (DMEM_READY) begin
                    if (class_q == CLS_STORE) begin
                        PCWE      = 1'b1;
                        instr_end = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                CRF       = 1'b1;
                PCWE      = 1'b1;
                instr_end = 1'b1;
                unique case (class_q)
                    CLS_LOAD: DWS = DWS_MEM;
                    CLS_LUI:  DWS = DWS_IMM;
                    CLS_JAL: begin
                        DWS = DWS_PC4;
                        PCS = PCS_PC_IMM;
                    end
                    CLS_JALR: begin
                        DWS = DWS_PC4;
                        PCS = PCS_RS1_IMM;
                    end
                    default:  DWS = DWS_ALU;
                endcase
            end

            ST_HALT: begin
                // Parked until reset; no strobes
            end

            default: state_d = ST_IDLE;
        endcase

        if (instr_end) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d   = RUN ? ST_FETCH : ST_IDLE;
        end
    end

    assign TRAP    = trap_q;
    assign STATE   = state_q;
    assign RETIRED = retired_q;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_riscv_mc_sequencer
// Directed plus randomized stimulus. Each instruction is expanded by a
// table-driven reference model (opcode -> which phases it visits and which
// selects it drives) into a per-cycle list of inputs and expected outputs,
// which is then played against the DUT cycle by cycle.
// -----------------------------------------------------------------------------
module tb_riscv_mc_sequencer;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             RUN;
    logic [6:0]       OP_CODE;
    logic [2:0]       FUNCT_3;
    logic             BR_TAKEN;
    logic             IMEM_READY;
    logic             DMEM_READY;
    logic             IMEM_REQ;
    logic             DMEM_REQ;
    logic             IRWE;
    logic             PCWE;
    logic             CRF;
    logic             CDM;
    logic [1:0]       PCS;
    logic [1:0]       DWS;
    logic             ALUS1;
    logic             ALUS2;
    logic             TRAP;
    logic [2:0]       STATE;
    logic [CNT_W-1:0] RETIRED;

    int checks = 0;
    int errors = 0;
    logic [15:0] retired_m;

    always #5 CLK = ~CLK;

    riscv_mc_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RUN        (RUN),
        .OP_CODE    (OP_CODE),
        .FUNCT_3    (FUNCT_3),
        .BR_TAKEN   (BR_TAKEN),
        .IMEM_READY (IMEM_READY),
        .DMEM_READY (DMEM_READY),
        .IMEM_REQ   (IMEM_REQ),
        .DMEM_REQ   (DMEM_REQ),
        .IRWE       (IRWE),
        .PCWE       (PCWE),
        .CRF        (CRF),
        .CDM        (CDM),
        .PCS        (PCS),
        .DWS        (DWS),
        .ALUS1      (ALUS1),
        .ALUS2      (ALUS2),
        .TRAP       (TRAP),
        .STATE      (STATE),
        .RETIRED    (RETIRED)
    );

    // One clock cycle: inputs to apply and outputs expected
    typedef struct packed {
        logic       rst;
        logic       run;
        logic [6:0] op;
        logic [2:0] f3;
        logic       br;
        logic       ir;
        logic       dr;
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       irwe;
        logic       pcwe;
        logic       crf;
        logic       cdm;
        logic [1:0] pcs;
        logic [1:0] dws;
        logic       a1;
        logic       a2;
        logic       trap;
    } step_t;

    // Behaviour of each opcode, straight from the instruction table
    typedef struct packed {
        logic       legal;
        logic       exec;
        logic       mem;
        logic       wb;
        logic       a1;
        logic       a2;
        logic       store;
        logic       branch;
        logic [1:0] dws;
        logic [1:0] wpcs;
    } info_t;

    function automatic info_t info(input logic [6:0] op);
        info_t f;
        f = '0;
        f.legal = 1'b1;
        case (op)
            7'b0110011: begin f.exec = 1; f.wb = 1; end
            7'b0010011: begin f.exec = 1; f.wb = 1; f.a2 = 1; end
            7'b0000011: begin f.exec = 1; f.mem = 1; f.wb = 1; f.a2 = 1; f.dws = 2'b01; end
            7'b0100011: begin f.exec = 1; f.mem = 1; f.a2 = 1; f.store = 1; end
            7'b1100011: begin f.exec = 1; f.branch = 1; end
            7'b0110111: begin f.wb = 1; f.dws = 2'b11; end
            7'b1101111: begin f.exec = 1; f.wb = 1; f.a1 = 1; f.a2 = 1; f.dws = 2'b10; f.wpcs = 2'b01; end
            7'b1100111: begin f.exec = 1; f.wb = 1; f.a2 = 1; f.dws = 2'b10; f.wpcs = 2'b10; end
            default:    f.legal = 1'b0;
        endcase
        return f;
    endfunction

    // Cycle in a given state with all strobes expected low and don't-care
    // inputs randomized (garbage opcode, stray READYs, toggling RUN).
    function automatic step_t mk(input logic [2:0] st);
        step_t s;
        s = '0;
        s.rst = 1'b1;
        s.run = 1'($urandom);
        s.op  = 7'($urandom);
        s.f3  = 3'($urandom);
        s.br  = 1'($urandom);
        s.ir  = 1'($urandom);
        s.dr  = 1'($urandom);
        s.st  = st;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic play(input string nm, input step_t s);
        RST        = s.rst;
        RUN        = s.run;
        OP_CODE    = s.op;
        FUNCT_3    = s.f3;
        BR_TAKEN   = s.br;
        IMEM_READY = s.ir;
        DMEM_READY = s.dr;
        @(negedge CLK);
        chk({nm, ".STATE"},    32'(STATE),    32'(s.st));
        chk({nm, ".IMEM_REQ"}, 32'(IMEM_REQ), 32'(s.imem_req));
        chk({nm, ".DMEM_REQ"}, 32'(DMEM_REQ), 32'(s.dmem_req));
        chk({nm, ".IRWE"},     32'(IRWE),     32'(s.irwe));
        chk({nm, ".PCWE"},     32'(PCWE),     32'(s.pcwe));
        chk({nm, ".CRF"},      32'(CRF),      32'(s.crf));
        chk({nm, ".CDM"},      32'(CDM),      32'(s.cdm));
        chk({nm, ".PCS"},      32'(PCS),      32'(s.pcs));
        chk({nm, ".DWS"},      32'(DWS),      32'(s.dws));
        chk({nm, ".ALUS1"},    32'(ALUS1),    32'(s.a1));
        chk({nm, ".ALUS2"},    32'(ALUS2),    32'(s.a2));
        chk({nm, ".TRAP"},     32'(TRAP),     32'(s.trap));
        chk({nm, ".RETIRED"},  32'(RETIRED),  32'(retired_m));
        @(posedge CLK);
        #1;
    endtask

    // Runs one instruction starting in FETCH and leaves the DUT in FETCH.
    // rst_at >= 0 pulls RST low during that cycle of the instruction.
    task automatic run_instr(input string nm, input logic [6:0] op, input logic br,
                             input int iw, input int dw, input logic run_after,
                             input int rst_at);
        info_t  inf;
        step_t  q[$];
        step_t  s;
        int     last;
        int     stop;
        logic   go_on;
        inf   = info(op);
        go_on = run_after;
        for (int i = 0; i < iw; i++) begin
            s = mk(3'd1); s.ir = 1'b0; s.imem_req = 1'b1; q.push_back(s);
        end
        s = mk(3'd1); s.ir = 1'b1; s.imem_req = 1'b1; s.irwe = 1'b1; q.push_back(s);
        s = mk(3'd2); s.op = op; q.push_back(s);
        if (!inf.legal) begin
            for (int i = 0; i < 3; i++) begin
                s = mk(3'd6); s.trap = 1'b1; q.push_back(s);
            end
            rst_at = q.size() - 1;
        end else begin
            if (inf.exec) begin
                s = mk(3'd3); s.a1 = inf.a1; s.a2 = inf.a2;
                if (inf.branch) begin
                    s.br = br; s.pcwe = 1'b1; s.pcs = br ? 2'b01 : 2'b00;
                end
                q.push_back(s);
            end
            if (inf.mem) begin
                for (int i = 0; i < dw; i++) begin
                    s = mk(3'd4); s.dr = 1'b0; s.dmem_req = 1'b1; s.cdm = inf.store; q.push_back(s);
                end
                s = mk(3'd4); s.dr = 1'b1; s.dmem_req = 1'b1; s.cdm = inf.store; s.pcwe = inf.store;
                q.push_back(s);
            end
            if (inf.wb) begin
                s = mk(3'd5); s.crf = 1'b1; s.pcwe = 1'b1; s.dws = inf.dws; s.pcs = inf.wpcs;
                q.push_back(s);
            end
            last = q.size() - 1;
            q[last].run = run_after;
        end
        if (rst_at >= 0) q[rst_at].rst = 1'b0;
        stop = (rst_at >= 0) ? rst_at : q.size() - 1;
        for (int i = 0; i <= stop; i++) play($sformatf("%s[%0d]", nm, i), q[i]);
        if (rst_at >= 0) begin
            retired_m = 16'h0000;
            go_on     = 1'b0;
        end else begin
            retired_m = retired_m + 16'h0001;
        end
        if (!go_on) begin
            s = mk(3'd0); s.run = 1'b0; play({nm, ".idle"}, s);
            s = mk(3'd0); s.run = 1'b1; play({nm, ".idle_go"}, s);
        end
        $display("instr %-10s op=%b iwait=%0d dwait=%0d cycles=%0d rst_at=%0d retired=%04h",
                 nm, op, iw, dw, stop + 1, rst_at, retired_m);
    endtask

    logic [6:0] legal_ops [8];

    initial begin
        step_t s;
        legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011;
        legal_ops[2] = 7'b0000011; legal_ops[3] = 7'b0100011;
        legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b0110111;
        legal_ops[6] = 7'b1101111; legal_ops[7] = 7'b1100111;

        RST = 1'b0; RUN = 1'b0; OP_CODE = '0; FUNCT_3 = '0;
        BR_TAKEN = 1'b0; IMEM_READY = 1'b0; DMEM_READY = 1'b0;
        retired_m = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;

        // Held in reset with RUN high: stays idle
        s = mk(3'd0); s.rst = 1'b0; s.run = 1'b1; play("reset", s);
        s = mk(3'd0); s.run = 1'b0; play("idle", s);
        s = mk(3'd0); s.run = 1'b1; play("idle_go", s);

        // Directed instructions
        run_instr("ADD",   7'b0110011, 1'b0, 0, 0, 1'b1, -1);
        run_instr("LW",    7'b0000011, 1'b0, 0, 2, 1'b1, -1);
        run_instr("SW",    7'b0100011, 1'b0, 1, 1, 1'b1, -1);
        run_instr("BNE",   7'b1100011, 1'b1, 0, 0, 1'b1, -1);
        run_instr("BGE",   7'b1100011, 1'b0, 0, 0, 1'b0, -1);
        run_instr("JAL",   7'b1101111, 1'b0, 0, 0, 1'b1, -1);
        run_instr("JALR",  7'b1100111, 1'b0, 2, 0, 1'b1, -1);
        run_instr("LUI",   7'b0110111, 1'b0, 0, 0, 1'b1, -1);
        run_instr("ADDI",  7'b0010011, 1'b0, 0, 0, 1'b0, -1);

        // Random legal instructions with random wait states and RUN
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            op = legal_ops[$urandom_range(0, 7)];
            run_instr($sformatf("rnd%0d", n), op, 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
        end

        // Counter wrap from all-ones
        dut.retired_q = 16'hFFFF;
        retired_m     = 16'hFFFF;
        run_instr("LUI_wrap", 7'b0110111, 1'b0, 0, 0, 1'b1, -1);

        // Reset while waiting in FETCH and while waiting in MEM
        dut.retired_q = 16'hFFFF;
        retired_m     = 16'hFFFF;
        run_instr("RST_FETCH", 7'b0110011, 1'b0, 2, 0, 1'b1, 1);
        dut.retired_q = 16'hFFFF;
        retired_m     = 16'hFFFF;
        run_instr("RST_MEM", 7'b0000011, 1'b0, 0, 2, 1'b1, 3);

        // Illegal opcode: halt with sticky trap until reset
        run_instr("ILLEGAL", 7'b0000000, 1'b0, 1, 0, 1'b1, -1);
        run_instr("ADD_post", 7'b0110011, 1'b0, 0, 0, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
